mem_fifo_loader: RTL
====================

MEM_FIFO_LOADER -- requirements
Module: mem_fifo_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, vector length, matrix row count and elements per memory line.
REQ-003 SHALL have parameter BASE_ADDR, default 32'd0, word address of matrix row 0.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle load request.
REQ-008 address  output  32  memory word address.
REQ-009 read  output  1  memory read request.
REQ-010 readdata  input  DATA_WIDTH*DEPTH  returned memory line.
REQ-011 readdatavalid  input  1  readdata valid this cycle.
REQ-012 waitrequest  input  1  memory stall; read not accepted while high.
REQ-013 clr  output  1  one-cycle clear pulse to downstream MAC array.
REQ-014 a_wren  output  DEPTH  one-hot matrix-row FIFO write enables.
REQ-015 b_wren  output  1  vector FIFO write enable.
REQ-016 fifo_data  output  DATA_WIDTH  element written to the enabled FIFO.
REQ-017 busy  output  1  high from start acceptance until DONE entered.
REQ-018 done  output  1  high while in DONE.

Function
REQ-019 SHALL implement states IDLE, REQ, WAIT, SHIFT, DONE.
REQ-020 IDLE or DONE with start=1 -> REQ next cycle; line_idx<=0; clr=1 for exactly that cycle; done cleared.
REQ-021 start while in REQ, WAIT or SHIFT SHALL be ignored.
REQ-022 In REQ: read=1, address=BASE_ADDR+line_idx; both held stable until accepted by waitrequest=0.
REQ-023 REQ with waitrequest=0 -> WAIT next cycle; read=0 outside REQ.
REQ-024 In WAIT, readdatavalid=1 SHALL latch readdata into a line buffer, byte_cnt<=0, -> SHIFT.
REQ-025 readdatavalid SHALL be ignored in IDLE, REQ, SHIFT and DONE; one read outstanding maximum.
REQ-026 SHIFT SHALL last exactly DEPTH cycles; in cycle k (0..DEPTH-1) fifo_data = buffer bits [W-1-k*DATA_WIDTH -: DATA_WIDTH], W=DATA_WIDTH*DEPTH (MS element first).
REQ-027 During SHIFT with line_idx<DEPTH: a_wren[line_idx]=1, other bits 0, b_wren=0.
REQ-028 During SHIFT with line_idx==DEPTH: b_wren=1, a_wren=0.
REQ-029 a_wren and b_wren SHALL be 0 outside SHIFT; never more than one enable bit high.
REQ-030 Last SHIFT cycle: line_idx<DEPTH -> line_idx+1, -> REQ; line_idx==DEPTH -> DONE.
REQ-031 Total lines read per load SHALL be DEPTH+1 (rows 0..DEPTH-1 then vector).
REQ-032 busy = state in {REQ, WAIT, SHIFT}; done = state==DONE, held until start or reset.
REQ-033 line_idx SHALL be ceil(log2(DEPTH+1)) bits; byte_cnt ceil(log2(DEPTH)) bits, wraps to 0 on exit.
REQ-034 fifo_data SHALL be 0 outside SHIFT.

Reset
REQ-035 rst_n=0 at any time, including mid-read, SHALL immediately force IDLE; line_idx, byte_cnt, buffer=0; read, clr, a_wren, b_wren, busy, done=0; fifo_data=0; address=BASE_ADDR.
REQ-036 A readdatavalid arriving after reset release for a read issued before reset SHALL be ignored (state IDLE).

Verification
REQ-037 Zero-wait memory, readdatavalid 1 cycle after accept, line r = bytes {r,r,...}+0x10*k pattern, start -> a_wren[r] high 8 cycles with fifo_data 0x?7..0x?0 order matching MS-first; b_wren 8 cycles; done after 9*(8+2)=90 cycles.
REQ-038 waitrequest=1 for 5 cycles on address 3 -> read and address=3 held 5 cycles stable, no enables, then normal completion.
REQ-039 Spurious readdatavalid during SHIFT and IDLE -> no buffer change, no extra writes; total a_wren pulses=64, b_wren pulses=8.
REQ-040 start pulsed during SHIFT of row 2 -> ignored, no clr; start in DONE -> clr one cycle, done=0, sequence repeats from address 0.
REQ-041 rst_n low during WAIT of row 5 -> all outputs 0 next cycle; late readdatavalid ignored; new start reads from address 0.
REQ-042 readdata=64'h0102030405060708 on vector line -> fifo_data 01,02,...,08 with b_wren=1 each cycle.

Source files
------------

// File: rtl/mem_fifo_loader.sv
// Loads DEPTH matrix rows and one vector line from a word-addressed memory and
// serialises each line, most-significant element first, into the row/vector FIFOs.
module mem_fifo_loader #(
  parameter int          DATA_WIDTH = 8,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'd0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [31:0]                 address,
  output logic                        read,
  input  logic [DATA_WIDTH*DEPTH-1:0] readdata,
  input  logic                        readdatavalid,
  input  logic                        waitrequest,
  output logic                        clr,
  output logic [DEPTH-1:0]            a_wren,
  output logic                        b_wren,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        busy,
  output logic                        done
);

  localparam int LINE_W = DATA_WIDTH * DEPTH;
  localparam int IDX_W  = $clog2(DEPTH + 1);
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Line index DEPTH is the vector line; 0..DEPTH-1 are matrix rows.
  localparam logic [IDX_W-1:0] VEC_LINE  = IDX_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    line_idx;
  logic [CNT_W-1:0]    byte_cnt;
  logic [LINE_W-1:0]   buffer;
  logic                accept_start;
  logic                last_elem;

  assign accept_start = ((state == IDLE) || (state == DONE)) && start;
  assign last_elem    = (byte_cnt == LAST_ELEM);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps these blocks free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start)          state_next = REQ;
      REQ:        if (!waitrequest)   state_next = WAIT;
      WAIT:       if (readdatavalid)  state_next = SHIFT;
      SHIFT:      if (last_elem)      state_next = (line_idx == VEC_LINE) ? DONE : REQ;
      default:                        state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      line_idx <= '0;
      byte_cnt <= '0;
      buffer   <= '0;
      clr      <= 1'b0;
    end else begin
      state <= state_next;
      clr   <= accept_start;
      case (state)
        IDLE, DONE: begin
          if (start) line_idx <= '0;
        end
        WAIT: begin
          if (readdatavalid) begin
            buffer   <= readdata;
            byte_cnt <= '0;
          end
        end
        SHIFT: begin
          byte_cnt <= last_elem ? '0 : byte_cnt + 1'b1;
          if (last_elem && (line_idx != VEC_LINE)) line_idx <= line_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so they drop with reset at once.
  always_comb begin
    address   = BASE_ADDR + 32'(line_idx);
    read      = (state == REQ);
    busy      = (state == REQ) || (state == WAIT) || (state == SHIFT);
    done      = (state == DONE);
    a_wren    = '0;
    b_wren    = 1'b0;
    fifo_data = '0;
    if (state == SHIFT) begin
      fifo_data = buffer[(LINE_W - 1) - int'(byte_cnt) * DATA_WIDTH -: DATA_WIDTH];
      if (line_idx == VEC_LINE) b_wren = 1'b1;
      else                      a_wren = DEPTH'(1) << line_idx;
    end
  end

endmodule
